snake_renderer: RTL and testbench
=================================

Name: snake_renderer

Overview:
Pixel-side reader of the game state that snake_core writes. It takes the raster position from display_controller, and captures a per-frame shadow copy of segment locations, length, food and the game-over flag during vertical blank so that a core update cannot tear the image. It then produces the 12-bit rgb for each pixel through a fixed 2-stage pipeline. It sits between snake_core / display_controller and the vgaR/vgaG/vgaB pins.

Parameters:
GRID_BITS, 4, bits per grid coordinate; the grid is 16x16 cells
CELL_SHIFT, 4, log2 of the cell size in pixels; cells are 16x16 px
NSEG, 8, maximum number of snake segments
H_ORG, 336, hCount of the board's left edge (144 + 192)
V_ORG, 147, vCount of the board's top edge (35 + 112)
V_SNAP, 515, vCount line on which the snapshot is taken (first vblank line)

Ports:
clk  in  1  pixel-rate clock, same clock as display_controller
rst  in  1  synchronous, active-high reset
bright  in  1  visible-region flag from display_controller
hCount  in  10  horizontal raster count
vCount  in  10  vertical raster count
loc_flat  in  NSEG*16  segment i is at [16*i+15:16*i] = {x[7:0], y[7:0]}; segment 0 is the head
length  in  4  number of live segments
food  in  8  {x[3:0], y[3:0]}
dead  in  1  game-over flag (Qe)
snap_pulse  out  1  one-cycle strobe in the cycle the shadow registers load
rgb  out  12  {R[3:0], G[3:0], B[3:0]}

Behaviour:
- Reset (synchronous, active-high, takes effect at the next clk edge):
  - rgb = 12'h000, snap_pulse = 0.
  - Pipeline valid/bright bits cleared.
  - Shadow length = 0, shadow dead = 0, snap_valid = 0.
- Snapshot:
  - Condition: vCount == V_SNAP && hCount == 0 && !rst.
  - In that cycle, loc_flat, length, food and dead load into the shadow registers, snap_valid is set, and snap_pulse = 1 for exactly one cycle.
  - Shadows are never written at any other time; input changes mid-frame have no visible effect until the next V_SNAP.
- Length handling: shadow length > NSEG is clamped to NSEG at load. Length 0 draws no segments.
- Stage 1 (registered):
  - dx = hCount - H_ORG and dy = vCount - V_ORG, 10-bit unsigned subtraction.
  - in_board = (hCount >= H_ORG) && (dx >> CELL_SHIFT) < 2^GRID_BITS, and the same test for y.
  - cx = dx[CELL_SHIFT +: GRID_BITS], cy likewise.
  - bright is delayed alongside.
- Stage 2 (registered into rgb):
  - seg_hit[i] = (i < shadow length) && loc x[7:GRID_BITS] == 0 && loc y[7:GRID_BITS] == 0 && x, y low bits == cx, cy.
  - A segment whose high bits are nonzero is off-grid and never drawn.
- Colour priority, highest first:
  - !bright → 000
  - !in_board → 000
  - !snap_valid → 222
  - seg_hit[0] → dead ? F80 : 0F0
  - any seg_hit[1..] → dead ? F80 : 080
  - food cell → F00
  - otherwise → 222
- Latency: rgb at edge n+2 corresponds to hCount/vCount sampled at edge n. No stalls; one pixel per clk.
- Simultaneous events:
  - A head and body segment on the same cell (self-collision) shows head colour.
  - A segment on the food cell shows segment colour.
  - Snapshot and reset in the same cycle: reset wins, no load, snap_pulse = 0.
- Reset mid-frame: rgb is 000 from the next edge until pipeline data refills (2 cycles). Board pixels show 222 until the first snapshot after reset.
- Wrap-around: no special case. Pixels left of or above the origin fail in_board, including the dx underflow case.

Decomposition:
- snake_pkg (header/package) holds:
  - GRID_BITS, CELL_SHIFT, NSEG
  - colour constants: C_BLACK = 000, C_BOARD = 222, C_HEAD = 0F0, C_BODY = 080, C_FOOD = F00, C_DEAD = F80
  - location field positions (X_MSB = 15, X_LSB = 8, Y_MSB = 7, Y_LSB = 0), shared with snake_core
- One natural sub-module, snake_cell_match. It is combinational, takes one 16-bit location, its index, the shadow length, cx and cy, and outputs hit. It is instantiated NSEG times via generate.

Test Plan:
1. Reset asserted for 3 clk, then released → rgb = 000 and snap_pulse = 0 during and after reset. The board pixel at (hCount 336, vCount 147) with bright = 1 shows 222 before any snapshot.
2. length = 3, seg0 = {x3,y2}, seg1 = {x2,y2}, seg2 = {x1,y2}, food = 8'h55, then run a frame past V_SNAP:
   - snap_pulse high exactly 1 cycle at vCount 515, hCount 0.
   - Next frame, hCount 336+48, vCount 147+32 → 0F0, two cycles later.
   - hCount 368 → 080.
   - hCount 416, vCount 227 → F00.
3. Change loc_flat and food mid-frame at vCount 300 → rgb for the remainder of that frame is unchanged. New positions appear only after the next snap_pulse.
4. length = 12 with all 8 segments distinct → 8 segments drawn, no X/garbage. length = 0 → no green anywhere, food still F00.
5. dead = 1 latched at snapshot → head and body cells F80. Head and seg1 both at {x5,y5} → F80 (head-priority path); repeat with dead = 0 → 0F0.
6. Boundaries:
   - hCount 335 and 592 → 000 (outside board); hCount 591 → in board.
   - seg x = 8'h1F → not drawn.
   - bright = 0 over the board → 000.
   - rst pulsed in the V_SNAP cycle → no snap_pulse, snap_valid stays 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants for the snake game: grid geometry, segment field layout and palette.
package snake_pkg;

  localparam int unsigned GRID_BITS  = 4;
  localparam int unsigned CELL_SHIFT = 4;
  localparam int unsigned NSEG       = 8;
  localparam int unsigned LEN_W      = 4;

  // Segment location word layout, shared with snake_core.
  localparam int unsigned X_MSB = 15;
  localparam int unsigned X_LSB = 8;
  localparam int unsigned Y_MSB = 7;
  localparam int unsigned Y_LSB = 0;

  localparam logic [11:0] C_BLACK = 12'h000;
  localparam logic [11:0] C_BOARD = 12'h222;
  localparam logic [11:0] C_HEAD  = 12'h0F0;
  localparam logic [11:0] C_BODY  = 12'h080;
  localparam logic [11:0] C_FOOD  = 12'hF00;
  localparam logic [11:0] C_DEAD  = 12'hF80;

  // Lengths above the segment storage would index segments that do not exist.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(NSEG)) ? LEN_W'(NSEG) : len;
  endfunction

endpackage

// File: rtl/snake_cell_match.sv
// Decides whether one snake segment occupies the grid cell currently being drawn.
module snake_cell_match
  import snake_pkg::*;
(
  input  logic [15:0]          loc,
  input  logic [LEN_W-1:0]     idx,
  input  logic [LEN_W-1:0]     len,
  input  logic [GRID_BITS-1:0] cx,
  input  logic [GRID_BITS-1:0] cy,
  output logic                 hit
);

  logic [7:0] x;
  logic [7:0] y;

  assign x = loc[X_MSB:X_LSB];
  assign y = loc[Y_MSB:Y_LSB];

  // Segments beyond the live length or with nonzero high bits (off-grid) never match.
  always_comb begin
    hit = (idx < len) &&
          (x[7:GRID_BITS] == '0) && (y[7:GRID_BITS] == '0) &&
          (x[GRID_BITS-1:0] == cx) && (y[GRID_BITS-1:0] == cy);
  end

endmodule

// File: rtl/snake_renderer.sv
// Pixel-side renderer: snapshots game state in vblank, then colours each pixel
// through a fixed two-stage pipeline (board coordinates, then colour lookup).
module snake_renderer
  import snake_pkg::*;
#(
  parameter int unsigned H_ORG  = 336,
  parameter int unsigned V_ORG  = 147,
  parameter int unsigned V_SNAP = 515
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bright,
  input  logic [9:0]        hCount,
  input  logic [9:0]        vCount,
  input  logic [NSEG*16-1:0] loc_flat,
  input  logic [3:0]        length,
  input  logic [7:0]        food,
  input  logic              dead,
  output logic              snap_pulse,
  output logic [11:0]       rgb
);

  // Shadow copy of the game state, stable for a whole frame.
  logic [NSEG*16-1:0] loc_sh;
  logic [LEN_W-1:0]   len_sh;
  logic [7:0]         food_sh;
  logic               dead_sh;
  logic               snap_valid;
  logic               snap;

  // Stage 1 registers.
  logic                 s1_bright;
  logic                 s1_in_board;
  logic [GRID_BITS-1:0] s1_cx;
  logic [GRID_BITS-1:0] s1_cy;

  logic [9:0]           dx;
  logic [9:0]           dy;
  logic                 in_x;
  logic                 in_y;

  logic [NSEG-1:0]      seg_hit;
  logic                 food_hit;
  logic [11:0]          colour;

  assign snap = (vCount == 10'(V_SNAP)) && (hCount == '0) && !rst;

  // Snapshot control state and strobe; reset wins over a coincident snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_sh     <= '0;
      dead_sh    <= 1'b0;
      snap_valid <= 1'b0;
      snap_pulse <= 1'b0;
    end else begin
      snap_pulse <= snap;
      if (snap) begin
        len_sh     <= clamp_len(length);
        dead_sh    <= dead;
        snap_valid <= 1'b1;
      end
    end
  end

  // Shadow data words; meaningless until snap_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (snap) begin
      loc_sh  <= loc_flat;
      food_sh <= food;
    end
  end

  // Board-relative offsets; an underflow yields a large dx/dy that fails the range test.
  always_comb begin
    dx   = hCount - 10'(H_ORG);
    dy   = vCount - 10'(V_ORG);
    in_x = (hCount >= 10'(H_ORG)) && ((dx >> CELL_SHIFT) < 10'(1 << GRID_BITS));
    in_y = (vCount >= 10'(V_ORG)) && ((dy >> CELL_SHIFT) < 10'(1 << GRID_BITS));
  end

  // Stage 1: register cell coordinates, board membership and the visible flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_bright   <= 1'b0;
      s1_in_board <= 1'b0;
      s1_cx       <= '0;
      s1_cy       <= '0;
    end else begin
      s1_bright   <= bright;
      s1_in_board <= in_x && in_y;
      s1_cx       <= dx[CELL_SHIFT +: GRID_BITS];
      s1_cy       <= dy[CELL_SHIFT +: GRID_BITS];
    end
  end

  for (genvar i = 0; i < NSEG; i++) begin : g_seg
    snake_cell_match u_match (
      .loc (loc_sh[16*i +: 16]),
      .idx (LEN_W'(i)),
      .len (len_sh),
      .cx  (s1_cx),
      .cy  (s1_cy),
      .hit (seg_hit[i])
    );
  end

  // Colour priority: blanking, off-board, no snapshot yet, head, body, food, empty cell.
  always_comb begin
    food_hit = (food_sh[7:4] == s1_cx) && (food_sh[3:0] == s1_cy);
    colour   = C_BOARD;
    if (!s1_bright || !s1_in_board) begin
      colour = C_BLACK;
    end else if (!snap_valid) begin
      colour = C_BOARD;
    end else if (seg_hit[0]) begin
      colour = dead_sh ? C_DEAD : C_HEAD;
    end else if (|seg_hit[NSEG-1:1]) begin
      colour = dead_sh ? C_DEAD : C_BODY;
    end else if (food_hit) begin
      colour = C_FOOD;
    end
  end

  // Stage 2: register the pixel colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb <= C_BLACK;
    end else begin
      rgb <= colour;
    end
  end

endmodule

// File: tb/tb_snake_renderer.sv
// Directed self-checking bench for snake_renderer: table-driven pixel checks plus
// hand-written sequences for snapshot timing, latency and reset corner cases.
module tb_snake_renderer;

  localparam int V_SNAP = 515;

  logic         clk;
  logic         rst;
  logic         bright;
  logic [9:0]   hCount;
  logic [9:0]   vCount;
  logic [127:0] loc_flat;
  logic [3:0]   length;
  logic [7:0]   food;
  logic         dead;
  logic         snap_pulse;
  logic [11:0]  rgb;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int snaps_expected = 0;

  typedef struct {
    string       name;
    int          h;
    int          v;
    logic        b;
    logic [11:0] exp;
  } vec_t;

  vec_t vq[$];

  snake_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .bright     (bright),
    .hCount     (hCount),
    .vCount     (vCount),
    .loc_flat   (loc_flat),
    .length     (length),
    .food       (food),
    .dead       (dead),
    .snap_pulse (snap_pulse),
    .rgb        (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (snap_pulse === 1'b1) pulse_cnt++;
  end

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic set_seg(input int i, input logic [7:0] x, input logic [7:0] y);
    loc_flat[16*i +: 16] = {x, y};
  endtask

  task automatic pixel(input string name, input int h, input int v, input logic b,
                       input logic [11:0] exp);
    hCount = 10'(h);
    vCount = 10'(v);
    bright = b;
    repeat (2) @(posedge clk);
    #1;
    check(name, rgb, exp);
  endtask

  function automatic void add(input string name, input int h, input int v, input logic b,
                              input logic [11:0] exp);
    vec_t t;
    t.name = name;
    t.h    = h;
    t.v    = v;
    t.b    = b;
    t.exp  = exp;
    vq.push_back(t);
  endfunction

  task automatic run_vecs();
    for (int i = 0; i < vq.size(); i++) pixel(vq[i].name, vq[i].h, vq[i].v, vq[i].b, vq[i].exp);
    vq.delete();
  endtask

  task automatic snap();
    hCount = '0;
    vCount = 10'(V_SNAP);
    bright = 1'b0;
    check("snap_pre", {11'b0, snap_pulse}, 12'h000);
    @(posedge clk);
    #1;
    check("snap_hi", {11'b0, snap_pulse}, 12'h001);
    snaps_expected++;
    hCount = 10'd1;
    @(posedge clk);
    #1;
    check("snap_lo", {11'b0, snap_pulse}, 12'h000);
  endtask

  initial begin
    rst      = 1'b1;
    bright   = 1'b0;
    hCount   = '0;
    vCount   = '0;
    loc_flat = '0;
    length   = '0;
    food     = '0;
    dead     = 1'b0;

    // Reset held for three clocks.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_rgb", rgb, 12'h000);
      check("rst_snap", {11'b0, snap_pulse}, 12'h000);
    end
    rst = 1'b0;
    pixel("pre_snap_board", 336, 147, 1'b1, 12'h222);

    // Basic frame: three segments in a row, food at (5,5).
    length = 4'd3;
    set_seg(0, 8'd3, 8'd2);
    set_seg(1, 8'd2, 8'd2);
    set_seg(2, 8'd1, 8'd2);
    for (int i = 3; i < 8; i++) set_seg(i, 8'd6, 8'd6);
    food = 8'h55;
    snap();
    add("head",         384, 179, 1'b1, 12'h0F0);
    add("body1",        368, 179, 1'b1, 12'h080);
    add("body2",        352, 179, 1'b1, 12'h080);
    add("body1_edge",   383, 179, 1'b1, 12'h080);
    add("food",         416, 227, 1'b1, 12'hF00);
    add("dead_len_seg", 432, 243, 1'b1, 12'h222);
    add("left_out",     335, 179, 1'b1, 12'h000);
    add("right_in",     591, 179, 1'b1, 12'h222);
    add("right_out",    592, 179, 1'b1, 12'h000);
    add("top_out",      384, 146, 1'b1, 12'h000);
    add("bottom_in",    384, 402, 1'b1, 12'h222);
    add("bottom_out",   384, 403, 1'b1, 12'h000);
    add("underflow",    100, 179, 1'b1, 12'h000);
    add("not_bright",   384, 179, 1'b0, 12'h000);
    run_vecs();

    // Two-cycle latency with back-to-back pixels.
    hCount = 10'd384;
    vCount = 10'd179;
    bright = 1'b1;
    @(posedge clk);
    #1;
    hCount = 10'd368;
    @(posedge clk);
    #1;
    check("lat_a", rgb, 12'h0F0);
    hCount = 10'd416;
    vCount = 10'd227;
    @(posedge clk);
    #1;
    check("lat_b", rgb, 12'h080);
    @(posedge clk);
    #1;
    check("lat_c", rgb, 12'hF00);

    // Mid-frame input changes stay invisible until the next snapshot.
    set_seg(0, 8'd10, 8'd10);
    food = 8'hAA;
    add("mid_old_head", 384, 179, 1'b1, 12'h0F0);
    add("mid_new_head", 496, 307, 1'b1, 12'h222);
    add("mid_old_food", 416, 227, 1'b1, 12'hF00);
    run_vecs();
    snap();
    add("new_head_on_food", 496, 307, 1'b1, 12'h0F0);
    add("old_head_gone",    384, 179, 1'b1, 12'h222);
    add("old_food_gone",    416, 227, 1'b1, 12'h222);
    add("body_kept",        368, 179, 1'b1, 12'h080);
    run_vecs();

    // Over-long length clamps to eight distinct segments; zero length draws nothing.
    for (int i = 0; i < 8; i++) set_seg(i, 8'(i), 8'd12);
    length = 4'd12;
    food   = 8'h0F;
    snap();
    add("long_head", 336, 339, 1'b1, 12'h0F0);
    add("long_seg4", 400, 339, 1'b1, 12'h080);
    add("long_seg7", 448, 339, 1'b1, 12'h080);
    add("long_past", 464, 339, 1'b1, 12'h222);
    add("long_food", 336, 387, 1'b1, 12'hF00);
    run_vecs();
    length = 4'd0;
    snap();
    add("len0_seg0", 336, 339, 1'b1, 12'h222);
    add("len0_seg7", 448, 339, 1'b1, 12'h222);
    add("len0_food", 336, 387, 1'b1, 12'hF00);
    run_vecs();

    // Game over colouring, including head and body on the same cell.
    length = 4'd3;
    set_seg(0, 8'd5, 8'd5);
    set_seg(1, 8'd5, 8'd5);
    set_seg(2, 8'd7, 8'd5);
    food = 8'h00;
    dead = 1'b1;
    snap();
    add("dead_head", 416, 227, 1'b1, 12'hF80);
    add("dead_body", 448, 227, 1'b1, 12'hF80);
    add("dead_food", 336, 147, 1'b1, 12'hF00);
    run_vecs();
    dead = 1'b0;
    snap();
    add("collide_head", 416, 227, 1'b1, 12'h0F0);
    add("alive_body",   448, 227, 1'b1, 12'h080);
    run_vecs();

    // Off-grid segments are never drawn.
    set_seg(0, 8'h1F, 8'h03);
    set_seg(1, 8'h01, 8'h23);
    set_seg(2, 8'h02, 8'h03);
    food = 8'hEE;
    snap();
    add("offgrid_x",  576, 195, 1'b1, 12'h222);
    add("offgrid_y",  352, 195, 1'b1, 12'h222);
    add("ongrid_seg", 368, 195, 1'b1, 12'h080);
    add("food_ee",    560, 371, 1'b1, 12'hF00);
    run_vecs();

    // Reset coinciding with the snapshot line: no load, no strobe, pipeline refills.
    rst    = 1'b1;
    hCount = '0;
    vCount = 10'(V_SNAP);
    bright = 1'b1;
    @(posedge clk);
    #1;
    check("rstsnap_pulse", {11'b0, snap_pulse}, 12'h000);
    check("rstsnap_rgb", rgb, 12'h000);
    rst    = 1'b0;
    hCount = 10'd368;
    vCount = 10'd195;
    @(posedge clk);
    #1;
    check("refill_pulse", {11'b0, snap_pulse}, 12'h000);
    check("refill_rgb", rgb, 12'h000);
    @(posedge clk);
    #1;
    check("no_snap_board", rgb, 12'h222);
    pixel("no_snap_food", 560, 371, 1'b1, 12'h222);

    check("pulse_count", 12'(pulse_cnt), 12'(snaps_expected));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
